reg_cmd_sequencer: RTL

//  Synthesizable, parametrised command initiator for the register bus (IDLE/RD/WR; 2'b11 invalid).

---
 rtl/reg_cmd_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/reg_cmd_sequencer.sv
// reg_cmd_sequencer
//   Command initiator for the register bus. Requests arrive over a
//   valid/ready port, are buffered in a DEPTH-entry FIFO and are issued one
//   per cycle as registered IDLE/RD/WR commands. IDLE_GAP forced bubbles can
//   follow every RD/WR. Read data is captured RD_LAT cycles after the RD and
//   returned together with its address.
//
// Ports
//   clk_i, rst_i                     clock, async active-high reset
//   req_valid_i/req_ready_o          request handshake
//   req_cmd_i/req_addr_i/req_data_i  request payload (cmd 2'b11 = invalid)
//   en_i                             issue enable (0 holds the FIFO)
//   flush_i                          drop every queued command
//   cmd_o/cmd_addr_o/cmd_data_o      registered bus command
//   cmd_data_i                       read data from the slave
//   rsp_valid_o/rsp_addr_o/rsp_data_o  read response (single-cycle pulse)
//   level_o                          FIFO occupancy
//   busy_o                           queued work, read in flight or gap
//   err_o                            pulse: invalid command dropped
module reg_cmd_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int RD_LAT   = 1,
    parameter int IDLE_GAP = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [1:0]                 req_cmd_i,
    input  logic [ADDR_W-1:0]          req_addr_i,
    input  logic [DATA_W-1:0]          req_data_i,
    input  logic                       en_i,
    input  logic                       flush_i,
    output logic [1:0]                 cmd_o,
    output logic [ADDR_W-1:0]          cmd_addr_o,
    output logic [DATA_W-1:0]          cmd_data_o,
    input  logic [DATA_W-1:0]          cmd_data_i,
    output logic                       rsp_valid_o,
    output logic [ADDR_W-1:0]          rsp_addr_o,
    output logic [DATA_W-1:0]          rsp_data_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;
    localparam logic [1:0] CMD_BAD  = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ISSUE = 2'b01;
    localparam logic [1:0] S_GAP   = 2'b10;

    // Asserts immediately, releases two clean edges after rst_i falls.
    logic [1:0] rst_sync;
    logic       rst_int;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rst_sync <= 2'b11;
        else       rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst_int = rst_sync[1];

    // FIFO storage
    logic [1:0]        mem_cmd  [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level;

    logic [1:0]  state;
    logic [3:0]  gap_cnt;

    logic [RD_LAT-1:0]             vld_pipe;
    logic [RD_LAT-1:0][ADDR_W-1:0] addr_pipe;

    logic full, empty, hs, bad, push, issue, rd_issue, head_rw;
    logic [1:0]        head_cmd;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // A full FIFO refuses even when the head pops in the same cycle.
    assign req_ready_o = !full && !flush_i && !rst_int;
    assign hs          = req_valid_i && req_ready_o;
    assign bad         = hs && (req_cmd_i == CMD_BAD);
    assign push        = hs && !bad;

    assign head_cmd  = mem_cmd[rd_ptr];
    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // Pop only from stored entries; a same-cycle push is not bypassed.
    assign issue    = (state != S_GAP) && en_i && !empty && !flush_i;
    assign rd_issue = issue && (head_cmd == CMD_RD);
    assign head_rw  = issue && ((head_cmd == CMD_RD) || (head_cmd == CMD_WR));

    assign level_o = level;
    assign busy_o  = !empty || (|vld_pipe) || (state == S_GAP);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_cmd[wr_ptr]  <= req_cmd_i;
            mem_addr[wr_ptr] <= req_addr_i;
            mem_data[wr_ptr] <= req_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_int) begin
        if (rst_int) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            state       <= S_IDLE;
            gap_cnt     <= '0;
            cmd_o       <= CMD_IDLE;
            cmd_addr_o  <= '0;
            cmd_data_o  <= '0;
            err_o       <= 1'b0;
            vld_pipe    <= '0;
            addr_pipe   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_addr_o  <= '0;
            rsp_data_o  <= '0;
        end else begin
            err_o <= bad;

            // Pointers wrap naturally; occupancy alone tells full from empty.
            if (flush_i) begin
                rd_ptr <= wr_ptr;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (issue) rd_ptr <= rd_ptr + PW'(1);
                level <= level + LW'(push) - LW'(issue);
            end

            // Bus: the popped head, IDLE otherwise. Address only for RD/WR,
            // data only for WR.
            if (issue) begin
                cmd_o      <= head_cmd;
                cmd_addr_o <= (head_cmd == CMD_IDLE) ? '0 : head_addr;
                cmd_data_o <= (head_cmd == CMD_WR) ? head_data : '0;
            end else begin
                cmd_o      <= CMD_IDLE;
                cmd_addr_o <= '0;
                cmd_data_o <= '0;
            end

            if (flush_i) begin
                state   <= S_IDLE;
                gap_cnt <= '0;
            end else if (state == S_GAP) begin
                // Counter was loaded with IDLE_GAP on the issuing edge, so
                // leaving at 1 gives exactly IDLE_GAP bubbles on the bus.
                if (gap_cnt <= 4'd1) begin
                    gap_cnt <= '0;
                    state   <= (en_i && !empty) ? S_ISSUE : S_IDLE;
                end else begin
                    gap_cnt <= gap_cnt - 4'd1;
                end
            end else if (issue) begin
                if (IDLE_GAP > 0 && head_rw) begin
                    state   <= S_GAP;
                    gap_cnt <= 4'(IDLE_GAP);
                end else begin
                    state <= S_ISSUE;
                end
            end else begin
                state <= S_IDLE;
            end

            // Read return pipe; deliberately untouched by flush.
            vld_pipe[0]  <= rd_issue;
            addr_pipe[0] <= head_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end

            rsp_valid_o <= vld_pipe[RD_LAT-1];
            if (vld_pipe[RD_LAT-1]) begin
                rsp_addr_o <= addr_pipe[RD_LAT-1];
                rsp_data_o <= cmd_data_i;
            end
        end
    end

endmodule
